// File: rtl/midi_tx_arbiter_pkg.sv
// Shared types, status-byte ranges and classification helper for the MIDI transmit arbiter.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACC  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam logic [7:0] STATUS_CH_MAX = 8'hEF;
    localparam logic [7:0] SYSCOM_MIN    = 8'hF0;
    localparam logic [7:0] RT_MIN        = 8'hF8;

    function automatic logic is_channel_status(input logic [7:0] s);
        return s[7] && (s <= STATUS_CH_MAX);
    endfunction

endpackage

// File: rtl/midi_tx_arbiter_if.sv
// Requester-side bundle: per-source request, message and length in; ack and error pulses out.
interface midi_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*24-1:0] msg;
    logic [NREQ*2-1:0]  len;
    logic [NREQ-1:0]    ack;
    logic               err;

    modport master (output req, msg, len, input ack, err);
    modport slave  (input req, msg, len, output ack, err);
endinterface

// File: rtl/midi_tx_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer, wrapping. Purely combinational.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);
    logic [IW:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!vld_o && req_i[cand[IW-1:0]]) begin
                vld_o             = 1'b1;
                gnt_o[cand[IW-1:0]] = 1'b1;
                idx_o             = cand[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/midi_tx_arbiter.sv
// Round-robin share of one MIDI UART among NREQ sources, with optional running-status compression.
// First tstart two cycles after grant-eligible req; each byte waits for the UART ready low/high cycle.
module midi_tx_arbiter
    import midi_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int RUNNING_STATUS = 1,
    parameter int RS_REFRESH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    midi_tx_arbiter_if.slave     src,
    input  logic                 tready,
    output logic                 tstart,
    output logic [7:0]           tbus,
    output logic                 busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, win_q, win_d;
    logic [23:0]     msg_q, msg_d;
    logic [1:0]      len_q, len_d, idx_q, idx_d;
    logic [7:0]      last_q, last_d;
    logic            lvld_q, lvld_d;
    logic [15:0]     rsc_q, rsc_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d, tstart_q, tstart_d;
    logic [7:0]      tbus_q, tbus_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            gvld;
    logic [23:0]     g_msg;
    logic [1:0]      g_len;
    logic [7:0]      g_stat, cur_byte;
    logic            rs_hit;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i (src.req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .vld_o (gvld)
    );

    assign g_msg  = src.msg[24*int'(gidx) +: 24];
    assign g_len  = src.len[2*int'(gidx) +: 2];
    assign g_stat = g_msg[23:16];

    // A one-byte message never loses its status, otherwise nothing would be sent.
    assign rs_hit = lvld_q && (g_stat == last_q) && (g_len != 2'd1)
                 && ((RS_REFRESH == 0) || (32'(rsc_q) < RS_REFRESH));

    assign cur_byte = (idx_q == 2'd0) ? msg_q[23:16] :
                      (idx_q == 2'd1) ? msg_q[15:8]  : msg_q[7:0];

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] w);
        return (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        msg_d    = msg_q;
        len_d    = len_q;
        idx_d    = idx_q;
        last_d   = last_q;
        lvld_d   = lvld_q;
        rsc_d    = rsc_q;
        ack_d    = '0;
        err_d    = 1'b0;
        tstart_d = 1'b0;
        tbus_d   = tbus_q;
        case (state_q)
            IDLE: begin
                if (gvld) begin
                    if (!g_stat[7] || (g_len == 2'd0)) begin
                        ack_d = gnt;
                        err_d = 1'b1;
                        ptr_d = ptr_after(gidx);
                    end else begin
                        msg_d   = g_msg;
                        len_d   = g_len;
                        win_d   = gidx;
                        idx_d   = 2'd0;
                        state_d = SEND;
                        if (RUNNING_STATUS != 0) begin
                            if (is_channel_status(g_stat)) begin
                                if (rs_hit) begin
                                    idx_d = 2'd1;
                                    rsc_d = (rsc_q == 16'hFFFF) ? rsc_q : rsc_q + 16'd1;
                                end else begin
                                    rsc_d  = '0;
                                    last_d = g_stat;
                                    lvld_d = 1'b1;
                                end
                            end else if ((g_stat >= SYSCOM_MIN) && (g_stat < RT_MIN)) begin
                                // System common breaks running status; realtime leaves it alone.
                                lvld_d = 1'b0;
                                rsc_d  = '0;
                            end
                        end
                    end
                end
            end
            SEND: begin
                if (tready) begin
                    tbus_d   = cur_byte;
                    tstart_d = 1'b1;
                    state_d  = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                if (!tready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tready) begin
                    if (({1'b0, idx_q} + 3'd1) < {1'b0, len_q}) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end else begin
                        ack_d[win_q] = 1'b1;
                        ptr_d        = ptr_after(win_q);
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            msg_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            lvld_q   <= 1'b0;
            rsc_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            tstart_q <= 1'b0;
            tbus_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            msg_q    <= msg_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            lvld_q   <= lvld_d;
            rsc_q    <= rsc_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            tstart_q <= tstart_d;
            tbus_q   <= tbus_d;
        end
    end

    assign src.ack = ack_q;
    assign src.err = err_q;
    assign tstart  = tstart_q;
    assign tbus    = tbus_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Directed bench: three arbiter instances (default, no running status, refresh=2) each with a UART model.
module tb_midi_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req_v [3];
    logic [95:0] msg_v [3];
    logic [7:0]  len_v [3];
    logic [3:0]  ack_w [3];
    logic        err_w [3];
    logic        tstart_w [3];
    logic [7:0]  tbus_w [3];
    logic        busy_w [3];
    logic        tready_w [3] = '{1'b1, 1'b1, 1'b1};

    logic [7:0]  blog [3][128];
    int          bcnt [3] = '{0, 0, 0};
    int          ucnt [3] = '{0, 0, 0};
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    midi_tx_arbiter_if #(.NREQ(4)) sif0 ();
    midi_tx_arbiter_if #(.NREQ(4)) sif1 ();
    midi_tx_arbiter_if #(.NREQ(4)) sif2 ();

    assign sif0.req = req_v[0]; assign sif0.msg = msg_v[0]; assign sif0.len = len_v[0];
    assign sif1.req = req_v[1]; assign sif1.msg = msg_v[1]; assign sif1.len = len_v[1];
    assign sif2.req = req_v[2]; assign sif2.msg = msg_v[2]; assign sif2.len = len_v[2];
    assign ack_w[0] = sif0.ack; assign err_w[0] = sif0.err;
    assign ack_w[1] = sif1.ack; assign err_w[1] = sif1.err;
    assign ack_w[2] = sif2.ack; assign err_w[2] = sif2.err;

    midi_tx_arbiter #(.NREQ(4), .RUNNING_STATUS(1), .RS_REFRESH(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .src(sif0.slave), .tready(tready_w[0]),
        .tstart(tstart_w[0]), .tbus(tbus_w[0]), .busy(busy_w[0]));
    midi_tx_arbiter #(.NREQ(4), .RUNNING_STATUS(0), .RS_REFRESH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .src(sif1.slave), .tready(tready_w[1]),
        .tstart(tstart_w[1]), .tbus(tbus_w[1]), .busy(busy_w[1]));
    midi_tx_arbiter #(.NREQ(4), .RUNNING_STATUS(1), .RS_REFRESH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .src(sif2.slave), .tready(tready_w[2]),
        .tstart(tstart_w[2]), .tbus(tbus_w[2]), .busy(busy_w[2]));

    // UART model: ready drops the cycle after a start and returns 20 cycles later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (tstart_w[k]) begin
                blog[k][7'(bcnt[k])] <= tbus_w[k];
                bcnt[k]     <= bcnt[k] + 1;
                tready_w[k] <= 1'b0;
                ucnt[k]     <= 20;
            end else if (ucnt[k] > 0) begin
                ucnt[k] <= ucnt[k] - 1;
                if (ucnt[k] == 1) tready_w[k] <= 1'b1;
            end
        end
    end

    function automatic logic [7:0] byte_at(input int d, input int n);
        return blog[d][7'(n)];
    endfunction

    task automatic send_one(input int d, input int r, input logic [23:0] m, input logic [1:0] l,
                            output int nb, output int base, output int t_first, output int t_ack,
                            output bit err_seen, output bit busy_seen);
        int c0;
        bit done;
        base = bcnt[d]; t_first = -1; t_ack = -1; err_seen = 0; busy_seen = 1; done = 0;
        @(negedge clk);
        req_v[d][r] = 1'b1;
        msg_v[d][24*r +: 24] = m;
        len_v[d][2*r +: 2] = l;
        c0 = cyc;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (tstart_w[d] && t_first < 0) t_first = cyc - c0;
            if (ack_w[d][r]) begin
                done = 1; t_ack = cyc - c0; err_seen = err_w[d]; busy_seen = busy_w[d];
            end
        end
        req_v[d][r] = 1'b0;
        nb = bcnt[d] - base;
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout dut%0d req%0d: no ack within 3000 cycles", d, r);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (ack_w[d] !== 4'h0) begin errors++; $display("FAIL reset_ack dut%0d got %0h exp 0", d, ack_w[d]); end
            checks++; if (err_w[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d got %0b exp 0", d, err_w[d]); end
            checks++; if (tstart_w[d] !== 1'b0) begin errors++; $display("FAIL reset_tstart dut%0d got %0b exp 0", d, tstart_w[d]); end
            checks++; if (tbus_w[d] !== 8'h00) begin errors++; $display("FAIL reset_tbus dut%0d got %0h exp 00", d, tbus_w[d]); end
            checks++; if (busy_w[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %0b exp 0", d, busy_w[d]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int nb, base, tf, ta; bit es, bs;
        logic [7:0] exp_b [3];
        exp_b = '{8'h90, 8'h40, 8'h64};
        send_one(0, 0, 24'h904064, 2'd3, nb, base, tf, ta, es, bs);
        checks++; if (tf !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", tf); end
        checks++; if (nb !== 3) begin errors++; $display("FAIL single_nbytes got %0d exp 3", nb); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (byte_at(0, base + k) !== exp_b[k]) begin errors++; $display("FAIL single_byte%0d got %0h exp %0h", k, byte_at(0, base + k), exp_b[k]); end
        end
        checks++; if (ta !== 70) begin errors++; $display("FAIL single_ack_cycle got %0d exp 70", ta); end
        checks++; if (es !== 1'b0) begin errors++; $display("FAIL single_err got %0b exp 0", es); end
        checks++; if (bs !== 1'b0) begin errors++; $display("FAIL single_busy_after got %0b exp 0", bs); end
        @(negedge clk);
        checks++; if (ack_w[0] !== 4'h0) begin errors++; $display("FAIL single_ack_pulse got %0h exp 0", ack_w[0]); end
    endtask

    task automatic test_running_status;
        int nb, base, tf, ta; bit es, bs;
        logic [23:0] m [4];
        int exp_nb [4];
        logic [7:0] exp_first [4];
        m = '{24'hB00764, 24'h903C64, 24'h903E64, 24'h803C00};
        exp_nb = '{3, 3, 2, 3};
        exp_first = '{8'hB0, 8'h90, 8'h3E, 8'h80};
        for (int k = 0; k < 4; k++) begin
            send_one(0, 1, m[k], 2'd3, nb, base, tf, ta, es, bs);
            checks++; if (nb !== exp_nb[k]) begin errors++; $display("FAIL rs_nbytes msg%0d got %0d exp %0d", k, nb, exp_nb[k]); end
            checks++; if (byte_at(0, base) !== exp_first[k]) begin errors++; $display("FAIL rs_first msg%0d got %0h exp %0h", k, byte_at(0, base), exp_first[k]); end
        end
        checks++; if (byte_at(0, base - 1) !== 8'h64) begin errors++; $display("FAIL rs_omit_tail got %0h exp 64", byte_at(0, base - 1)); end
    endtask

    task automatic test_round_robin;
        int nb, base, tf, ta, n; bit es, bs, seen0;
        int order [5];
        int exp_o [5];
        exp_o = '{0, 1, 2, 3, 0};
        send_one(0, 3, 24'hFB0000, 2'd1, nb, base, tf, ta, es, bs);
        checks++; if (nb !== 1) begin errors++; $display("FAIL rr_setup_nbytes got %0d exp 1", nb); end
        @(negedge clk);
        msg_v[0] = {24'hFB0000, 24'hFA0000, 24'hF90000, 24'hF80000};
        len_v[0] = 8'b01010101;
        req_v[0] = 4'hF;
        base = bcnt[0]; n = 0; seen0 = 0;
        for (int i = 0; i < 2000 && n < 5; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                if (ack_w[0][j] && n < 5) begin
                    order[n] = j; n++;
                    if (j != 0 || seen0) req_v[0][j] = 1'b0;
                    if (j == 0) seen0 = 1;
                end
            end
        end
        req_v[0] = 4'h0;
        checks++; if (n !== 5) begin errors++; $display("FAIL rr_ack_count got %0d exp 5", n); end
        for (int k = 0; k < 5 && k < n; k++) begin
            checks++; if (order[k] !== exp_o[k]) begin errors++; $display("FAIL rr_order%0d got %0d exp %0d", k, order[k], exp_o[k]); end
            checks++; if (byte_at(0, base + k) !== 8'(8'hF8 + exp_o[k])) begin errors++; $display("FAIL rr_byte%0d got %0h exp %0h", k, byte_at(0, base + k), 8'(8'hF8 + exp_o[k])); end
        end
    endtask

    task automatic test_malformed_realtime;
        int nb, base, tf, ta; bit es, bs;
        logic [23:0] m [5];
        logic [1:0]  l [5];
        int exp_nb [5];
        logic [7:0] exp_first [5];
        send_one(0, 2, 24'h904064, 2'd0, nb, base, tf, ta, es, bs);
        checks++; if (es !== 1'b1) begin errors++; $display("FAIL drop_len0_err got %0b exp 1", es); end
        checks++; if (ta !== 1) begin errors++; $display("FAIL drop_len0_ack_cycle got %0d exp 1", ta); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL drop_len0_tstart got %0d bytes exp 0", nb); end
        send_one(0, 2, 24'h400000, 2'd2, nb, base, tf, ta, es, bs);
        checks++; if (es !== 1'b1) begin errors++; $display("FAIL drop_stat40_err got %0b exp 1", es); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL drop_stat40_tstart got %0d bytes exp 0", nb); end
        m = '{24'h903C64, 24'hF80000, 24'h903E64, 24'hF00000, 24'h904064};
        l = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
        exp_nb = '{3, 1, 2, 1, 3};
        exp_first = '{8'h90, 8'hF8, 8'h3E, 8'hF0, 8'h90};
        for (int k = 0; k < 5; k++) begin
            send_one(0, 1, m[k], l[k], nb, base, tf, ta, es, bs);
            checks++; if (nb !== exp_nb[k]) begin errors++; $display("FAIL rt_nbytes msg%0d got %0d exp %0d", k, nb, exp_nb[k]); end
            checks++; if (byte_at(0, base) !== exp_first[k]) begin errors++; $display("FAIL rt_first msg%0d got %0h exp %0h", k, byte_at(0, base), exp_first[k]); end
            checks++; if (es !== 1'b0) begin errors++; $display("FAIL rt_err msg%0d got %0b exp 0", k, es); end
        end
    endtask

    task automatic test_no_running_status;
        int nb, base, tf, ta; bit es, bs;
        for (int k = 0; k < 2; k++) begin
            send_one(1, 1, 24'h903C64, 2'd3, nb, base, tf, ta, es, bs);
            checks++; if (nb !== 3) begin errors++; $display("FAIL nors_nbytes msg%0d got %0d exp 3", k, nb); end
            checks++; if (byte_at(1, base) !== 8'h90) begin errors++; $display("FAIL nors_first msg%0d got %0h exp 90", k, byte_at(1, base)); end
        end
    endtask

    task automatic test_refresh;
        int nb, base, tf, ta; bit es, bs;
        int exp_nb [5];
        logic [7:0] exp_first;
        exp_nb = '{3, 2, 2, 3, 2};
        for (int k = 0; k < 5; k++) begin
            send_one(2, 0, {8'h90, 8'(8'h10 + k), 8'h64}, 2'd3, nb, base, tf, ta, es, bs);
            exp_first = (exp_nb[k] == 3) ? 8'h90 : 8'(8'h10 + k);
            checks++; if (nb !== exp_nb[k]) begin errors++; $display("FAIL refresh_nbytes msg%0d got %0d exp %0d", k, nb, exp_nb[k]); end
            checks++; if (byte_at(2, base) !== exp_first) begin errors++; $display("FAIL refresh_first msg%0d got %0h exp %0h", k, byte_at(2, base), exp_first); end
        end
    endtask

    task automatic test_reset_mid;
        int nb, base, tf, ta; bit es, bs, hit;
        base = bcnt[0]; hit = 0;
        @(negedge clk);
        req_v[0][0] = 1'b1;
        msg_v[0][23:0] = 24'h903C64;
        len_v[0][1:0] = 2'd3;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (bcnt[0] - base == 2) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_two_bytes got %0d bytes exp 2", bcnt[0] - base); end
        checks++; if (byte_at(0, base) !== 8'h3C) begin errors++; $display("FAIL rstmid_omitted got %0h exp 3C", byte_at(0, base)); end
        repeat (3) @(negedge clk);
        checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %0b exp 1", busy_w[0]); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b exp 0", busy_w[0]); end
        checks++; if (tbus_w[0] !== 8'h00) begin errors++; $display("FAIL rstmid_tbus got %0h exp 00", tbus_w[0]); end
        checks++; if (tstart_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_tstart got %0b exp 0", tstart_w[0]); end
        checks++; if (ack_w[0] !== 4'h0 || err_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_ack_err got %0h/%0b exp 0/0", ack_w[0], err_w[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        send_one(0, 0, 24'h903C64, 2'd3, nb, base, tf, ta, es, bs);
        checks++; if (nb !== 3) begin errors++; $display("FAIL rstmid_resend_nbytes got %0d exp 3", nb); end
        checks++; if (byte_at(0, base) !== 8'h90) begin errors++; $display("FAIL rstmid_resend_status got %0h exp 90", byte_at(0, base)); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_v[d] = '0; msg_v[d] = '0; len_v[d] = '0;
        end
        rst_n = 1'b0;
        test_reset;
        test_single;
        test_running_status;
        test_round_robin;
        test_malformed_realtime;
        test_no_running_status;
        test_refresh;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/midi_tx_arbiter.md
Name: midi_tx_arbiter

Overview:
Shares the single MIDI UART transmitter among NREQ independent message sources, such as key note on/off, program change and volume control change. It grants one requester at a time by round robin and serialises that requester's 1–3 byte MIDI message into the UART start/ready byte handshake. It optionally applies MIDI running status to drop repeated status bytes. It sits between the message generators and uart_tx, taking the place of a single-source byte sequencer.

Parameters:
NREQ, 4, number of requesters (2..8)
RUNNING_STATUS, 1, 1 = omit status byte when equal to last sent channel status
RS_REFRESH, 16, force status byte after this many consecutive running-status omissions (0 = never force)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester message request; held high until ack
msg  in  NREQ*24  per-requester message {status[23:16], data1[15:8], data2[7:0]}; requester i uses bits [24*i+23:24*i]
len  in  NREQ*2  per-requester byte count 1..3; requester i uses bits [2*i+1:2*i]
ack  out  NREQ  one-cycle pulse: message for requester i fully transmitted or dropped
err  out  1  one-cycle pulse: granted message dropped as malformed
tready  in  1  uart_tx ready (idle)
tstart  out  1  uart_tx start strobe
tbus  out  8  byte to uart_tx
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - outputs: ack=0, err=0, tstart=0, tbus=8'h00, busy=0
  - state=IDLE, rr pointer=0, last_status=none (valid bit 0), rs_count=0
- Reset mid-message: return to IDLE immediately and clear running status. A byte already accepted by the UART completes on its own. Requesters re-request.
- Registered outputs only. msg and len are latched at grant, so later changes to the requester's inputs are ignored.
- States and transitions:
  - IDLE: if |req, choose the winner as the first set bit at or after rr pointer, circular. Latch msg/len, validate, compute start index → SEND. Else stay.
  - SEND: when tready=1, drive tbus=current byte and tstart=1 for exactly one cycle → WAIT_ACC.
  - WAIT_ACC: stay until tready=0 → WAIT_DONE.
  - WAIT_DONE: stay until tready=1.
    - More bytes: idx+1 → SEND.
    - Else: ack[winner]=1 for one cycle, rr pointer=winner+1 mod NREQ → IDLE.
- tbus holds its value from the tstart cycle until the next byte is loaded.
- Validation (done in IDLE at grant):
  - status[7]=0 or len=0 → drop: ack[winner]=1 and err=1 in the same cycle, rr pointer advances, stay IDLE, no tstart.
  - len counts status+data bytes. Bytes are sent in order status, data1, data2, truncated to len.
- Running status (RUNNING_STATUS=1):
  - Omission rule: omit status iff status is in 8'h80–8'hEF, status == last_status, last_status valid, and (RS_REFRESH=0 or rs_count < RS_REFRESH).
    - On omit: start idx=1, rs_count+1.
    - Otherwise: start idx=0, rs_count=0, last_status=status.
  - If omission would leave zero bytes (len=1), the status byte is sent anyway.
  - 8'hF0–8'hF7: sent normally and invalidate last_status.
  - 8'hF8–8'hFF (realtime): sent and leave last_status and rs_count untouched.
- RUNNING_STATUS=0: always start at idx=0.
- Minimum latency: req high in IDLE at cycle N → tstart at N+2 when tready=1 throughout.
- Requests arriving while busy wait. Their req must stay high; there is no queueing beyond req.
- Fairness: a requester holding req is granted within NREQ messages.
- Simultaneous requests: resolved solely by rr pointer. A dropped message counts as a grant.

Decomposition:
- Package midi_pkg:
  - state enum {IDLE, SEND, WAIT_ACC, WAIT_DONE}
  - constants: STATUS_CH_MAX=8'hEF, SYSCOM_MIN=8'hF0, RT_MIN=8'hF8
  - function is_channel_status
- Sub-module rr_arbiter (req vector + pointer → one-hot grant and index) is a natural split. The byte sequencer stays in the top.

Test Plan:
- Single note-on: req[0], msg=24'h904064, len=3, uart model ready drops 1 cycle after start and returns after 20 cycles → tbus 90, 40, 64 in order, one tstart each, ack[0] after the third ready, busy low next cycle.
- Running status: requester 1 sends 90 3C 64 then 90 3E 64 → second message emits only 3E 64. A following 80 3C 00 emits its status. With RUNNING_STATUS=0, all bytes are sent.
- Refresh: RS_REFRESH=2, five identical 90 xx 64 messages → status sent on messages 1 and 4 only.
- Round robin: req=4'b1111 held with distinct messages, pointer 0 → grant order 0,1,2,3,0. Re-raising req[0] immediately after its ack still serves 1,2,3 first.
- Malformed and realtime: len=0 → ack and err same cycle, no tstart. Status 8'h40 → dropped with err. 8'hF8 with len=1 between two 90 messages → F8 sent and the second 90 still omitted. 8'hF0 message → next 90 sends its status.
- Reset: assert rst_n low during WAIT_DONE of byte 2 → outputs return to reset values asynchronously. After release, the re-requested message sends its full status byte.
